pipe_reg_elastic: RTL and testbench
===================================

Name: pipe_reg_elastic

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline with valid/ready flow control, bubble collapsing and an occupancy count.
- Used wherever the datapath needs N cycles of registered delay and must tolerate downstream stalls without losing or duplicating data.
- Sits between any valid/ready producer and consumer in the design.

Parameters:
- WIDTH, 8, data bits per stage; WIDTH >= 1.
- DEPTH, 4, number of register stages; DEPTH >= 1. DEPTH = 0 is illegal; elaboration fails via a generate-time check.
- OCC_W, $clog2(DEPTH+1), occupancy width. Derived; not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_data  input  WIDTH  upstream data.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  pipeline can accept in_data this cycle.
- out_data  output  WIDTH  head-stage data (stage DEPTH-1).
- out_valid  output  1  head stage holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.
- occupancy  output  OCC_W  number of valid stages, 0..DEPTH.
- flush  input  1  present only with FLUSH_PIPE_EN (see Optional Feature).

Behaviour:
- Stage structure:
  - Stages 0 (input side) to DEPTH-1 (output side).
  - Each stage k has data_k[WIDTH-1:0] and valid_k.
- Ready chain (combinational):
  - ready_DEPTH = out_ready.
  - ready_k = ~valid_k | ready_(k+1).
  - in_ready = ready_0 & ~rst.
  - The path from out_ready to in_ready is combinational by design; no skid buffer.
- Stage update, on posedge clk with rst = 0, for each k:
  - If ready_k: valid_k <= valid_(k-1), where valid_(-1) = in_valid.
  - If ready_k & valid_(k-1): data_k <= data_(k-1), where data_(-1) = in_data.
  - Otherwise the stage holds. Data is not overwritten by bubbles.
- Handshakes:
  - Input handshake = in_valid & in_ready.
  - Output handshake = out_valid & out_ready.
  - out_data and out_valid come directly from stage DEPTH-1 registers.
- Reset (synchronous):
  - All valid_k <= 0 and all data_k <= 0.
  - After the reset edge: out_valid = 0, out_data = 0, occupancy = 0, in_ready = 1.
  - While rst is high, in_ready = 0 and no input is accepted.
  - A reset asserted mid-stream discards all in-flight data; nothing is emitted.
- Latency and throughput:
  - An item accepted at edge t into an empty pipe with out_ready held at 1 appears with out_valid = 1 after edge t+DEPTH-1, i.e. DEPTH register stages.
  - Sustained throughput is 1 item per cycle.
- Stall: with out_ready = 0, items advance into bubbles until all DEPTH stages are valid. in_ready then drops to 0.
- Full pipe, out_ready = 1: output pop and input push happen on the same edge; occupancy is unchanged.
- Empty pipe, in_valid = 0: all stages stay invalid; out_valid = 0.
- Ordering: strictly FIFO. No item is dropped or duplicated under any in_valid/out_ready pattern.
- occupancy: combinational popcount of the valid_k registers. It is a function of registers only, so it is glitch-free at clock edges.
- Input stability: in_data/in_valid held while in_valid & ~in_ready is expected of upstream; the block does not check it.

Optional Feature:
- Macro: FLUSH_PIPE_EN.
- Defined:
  - The flush port exists.
  - While flush = 1: in_ready = 0 and out_valid = 0, so no handshakes occur.
  - On the edge with flush = 1, all valid_k <= 0. Data registers hold.
  - The cycle after: occupancy = 0, in_ready = 1.
  - flush and rst together behave as rst.
- Undefined:
  - No flush port.
  - in_ready and out_valid are as described above with no flush terms.

Test Plan (WIDTH=8, DEPTH=3):
- Reset then push 0xA5 with out_ready=1 -> out_valid rises with out_data=0xA5 exactly 3 edges after acceptance; occupancy returns to 0 one edge after the pop.
- Stream 0x01..0x0A back-to-back, out_ready=1 -> 10 consecutive output handshakes in order; in_ready stays 1 throughout.
- out_ready=0, push 0x11,0x22,0x33,0x44 -> first three accepted, occupancy=3, in_ready=0 while 0x44 is offered; raise out_ready -> outputs 0x11,0x22,0x33,0x44 in order.
- Random in_valid/out_ready (50%, 10k cycles) against a scoreboard queue -> no loss, duplication or reordering; occupancy always equals the model count and never exceeds 3.
- Pipe holding 2 items, assert rst for 1 cycle -> out_valid=0, out_data=0x00, occupancy=0, in_ready=0 during rst and 1 after.
- FLUSH_PIPE_EN defined, pipe full, flush=1 for 1 cycle with in_valid=1 -> no handshake that cycle; next cycle occupancy=0, out_valid=0, and a new push of 0x5A emerges after 3 edges.

Source files
------------

// File: rtl/pipe_reg_elastic.sv
// WIDTH x DEPTH elastic register pipeline, valid/ready, bubble collapsing.
// Optional flush port with FLUSH_PIPE_EN.
module pipe_reg_elastic #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef FLUSH_PIPE_EN
  input  logic             flush,
`endif
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
);

  if (DEPTH < 1) begin : g_depth_chk
    $error("pipe_reg_elastic: DEPTH must be >= 1");
  end

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            rdy;
  logic                        bub;
  logic [OCC_W-1:0]            occ_c;

  // Stage k may load when any stage at or above k is a bubble, or the head pops.
  always_comb begin
    bub = 1'b0;
    rdy = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      bub    = bub | ~valid_q[k];
      rdy[k] = bub | out_ready;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (rdy[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) data_d[0] = in_data;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (rdy[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) data_d[k] = data_q[k-1];
      end
    end
`ifdef FLUSH_PIPE_EN
    if (flush) valid_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    occ_c = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_c = occ_c + OCC_W'(valid_q[k]);
    end
  end

  assign occupancy = occ_c;
  assign out_data  = data_q[DEPTH-1];

`ifdef FLUSH_PIPE_EN
  assign in_ready  = rdy[0] & ~rst & ~flush;
  assign out_valid = valid_q[DEPTH-1] & ~flush;
`else
  assign in_ready  = rdy[0] & ~rst;
  assign out_valid = valid_q[DEPTH-1];
`endif

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Randomised and directed bench for pipe_reg_elastic.
// Item-position reference model; WIDTH=8, DEPTH=3.
module tb_pipe_reg_elastic;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [OCC_W-1:0] occupancy;

  pipe_reg_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef FLUSH_PIPE_EN
    .flush     (flush),
`endif
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         pos;
  } item_t;

  item_t      mq[$];
  logic [7:0] got[$];
  int         hs_cyc[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic       s_ov, s_ir;
  logic [7:0] s_od;
  logic [OCC_W-1:0] s_occ;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: sample and check at negedge, then advance the model.
  task automatic step();
    int    mv[$];
    int    n;
    bit    fl, ov_e, ir_e, busy0, acc;
    item_t tmp;
    @(negedge clk);
    fl = 1'b0;
`ifdef FLUSH_PIPE_EN
    fl = flush;
`endif
    n = mq.size();
    for (int i = 0; i < n; i++) begin
      if (i == 0)
        mv.push_back((mq[0].pos != DEPTH-1 || out_ready) ? 1 : 0);
      else
        mv.push_back((mq[i].pos + 1 != mq[i-1].pos || mv[i-1] != 0) ? 1 : 0);
    end
    ov_e  = !fl && n > 0 && mq[0].pos == DEPTH-1;
    busy0 = n > 0 && mq[n-1].pos == 0 && mv[n-1] == 0;
    ir_e  = !rst && !fl && !busy0;
    s_ov  = out_valid;
    s_od  = out_data;
    s_ir  = in_ready;
    s_occ = occupancy;
    chk("out_valid", 32'(s_ov), 32'(ov_e));
    chk("in_ready", 32'(s_ir), 32'(ir_e));
    chk("occupancy", 32'(s_occ), n);
    if (ov_e) chk("out_data", 32'(s_od), 32'(mq[0].d));
    if (s_ov && out_ready && !rst) begin
      got.push_back(s_od);
      hs_cyc.push_back(cyc);
    end
    acc = in_valid && ir_e;
    @(posedge clk);
    cyc++;
    if (rst || fl) begin
      mq.delete();
    end else begin
      if (n > 0 && mv[0] != 0 && mq[0].pos == DEPTH-1) begin
        void'(mq.pop_front());
        void'(mv.pop_front());
      end
      for (int i = 0; i < mq.size(); i++) begin
        if (mv[i] != 0) begin
          tmp = mq[i];
          tmp.pos = tmp.pos + 1;
          mq[i] = tmp;
        end
      end
      if (acc) begin
        tmp.d = in_data;
        tmp.pos = 0;
        mq.push_back(tmp);
      end
    end
    #1;
  endtask

  task automatic drain(input int want);
    int n;
    n = 0;
    while (got.size() < want && n < 20) begin
      step();
      n++;
    end
    chk("drain_count", got.size(), want);
  endtask

  // Edges counted from the acceptance edge until out_valid is seen.
  task automatic wait_out(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!s_ov && n < 10);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    chk("rst_in_ready", 32'(s_ir), 0);
    rst = 1'b0;
  endtask

  int lat;

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    step();
    chk("por_out_valid", 32'(s_ov), 0);
    chk("por_out_data", 32'(s_od), 0);
    chk("por_occ", 32'(s_occ), 0);
    chk("por_in_ready", 32'(s_ir), 1);

    // single item latency
    got.delete();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    chk("latency", lat, DEPTH);
    chk("lat_data", 32'(s_od), 32'h A5);
    step();
    chk("occ_after_pop", 32'(s_occ), 0);

    // back-to-back stream
    got.delete(); hs_cyc.delete();
    for (int v = 1; v <= 10; v++) begin
      in_valid = 1'b1; in_data = 8'(v);
      step();
      chk("stream_in_ready", 32'(s_ir), 1);
    end
    in_valid = 1'b0;
    drain(10);
    for (int i = 0; i < got.size(); i++) begin
      chk("stream_data", 32'(got[i]), i + 1);
      chk("stream_gapless", hs_cyc[i] - hs_cyc[0], i);
    end

    // stall and release
    got.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; step();
    in_data = 8'h22; step();
    in_data = 8'h33; step();
    in_data = 8'h44;
    repeat (2) begin
      step();
      chk("stall_in_ready", 32'(s_ir), 0);
      chk("stall_occ", 32'(s_occ), 3);
    end
    out_ready = 1'b1;
    step();
    chk("release_accept", 32'(s_ir), 1);
    in_valid = 1'b0;
    drain(4);
    if (got.size() == 4) begin
      chk("stall_d0", 32'(got[0]), 32'h11);
      chk("stall_d1", 32'(got[1]), 32'h22);
      chk("stall_d2", 32'(got[2]), 32'h33);
      chk("stall_d3", 32'(got[3]), 32'h44);
    end

    // mid-stream reset
    got.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h66; step();
    in_data = 8'h77; step();
    chk("pre_rst_occ", 32'(s_occ), 1);
    rst = 1'b1; in_data = 8'h88;
    step();
    chk("rst_block", 32'(s_ir), 0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("rst_out_valid", 32'(s_ov), 0);
    chk("rst_out_data", 32'(s_od), 0);
    chk("rst_occ", 32'(s_occ), 0);
    chk("rst_in_ready", 32'(s_ir), 1);
    repeat (4) step();
    chk("rst_nothing_out", got.size(), 0);

`ifdef FLUSH_PIPE_EN
    got.delete();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h01; step();
    in_data = 8'h02; step();
    in_data = 8'h03; step();
    flush = 1'b1; in_data = 8'h77;
    step();
    chk("flush_in_ready", 32'(s_ir), 0);
    chk("flush_out_valid", 32'(s_ov), 0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("post_flush_occ", 32'(s_occ), 0);
    chk("post_flush_ov", 32'(s_ov), 0);
    chk("post_flush_ir", 32'(s_ir), 1);
    in_valid = 1'b1; in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    chk("flush_latency", lat, DEPTH);
    chk("flush_data", 32'(s_od), 32'h5A);
    step();
`endif

    // random traffic against the model
    got.delete();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom % 2);
      out_ready = 1'($urandom % 2);
      in_data   = 8'($urandom);
      step();
      if (s_occ > 3) chk("occ_bound", 32'(s_occ), 3);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 2) step();
    chk("rand_empty", 32'(s_occ), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
